branch_resolve_ctrl: RTL

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

---
 rtl/branch_resolve_ctrl_pkg.sv | 31 +++
 rtl/branch_cond_eval.sv | 23 ++
 rtl/branch_resolve_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller.
// Holds the op encodings, the FSM state encoding, the latched request layout and the target alignment helper.
package branch_resolve_ctrl_pkg;

  localparam int STAT_W_DEF = 16;

  localparam logic [3:0] OP_BEQ = 4'b0001;
  localparam logic [3:0] OP_BGT = 4'b0010;
  localparam logic [3:0] OP_BGE = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_REDIR = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs_a;
    logic [31:0] rs_b;
    logic [31:0] pc;
    logic [31:0] offset;
  } br_req_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition: BEQ, unsigned BGT/BGE, JMP; reserved ops never take.
// Zero latency, no flow control.
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        taken_o
);

  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_BEQ:  taken_o = (a_i == b_i);
      OP_BGT:  taken_o = (a_i > b_i);
      OP_BGE:  taken_o = (a_i >= b_i);
      OP_JMP:  taken_o = 1'b1;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve FSM: accept -> evaluate -> optional redirect handshake -> one-cycle done.
// Not-taken done at N+2; redirect offered at N+2 and held until redirect_ready; one request in flight.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [31:0]       req_rs_a,
  input  logic [31:0]       req_rs_b,
  input  logic [31:0]       req_pc,
  input  logic [31:0]       req_offset,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic              resolve_done,
  output logic              resolve_taken,
  output logic              resolve_err,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  br_req_t           req_q;
  logic              taken_q;
  logic [31:0]       target_q;
  logic [31:0]       target_d;
  logic              cond_taken;
  logic              redirected;
  logic [STAT_W-1:0] stat_taken_q, stat_nt_q;

  branch_cond_eval u_cond (
    .op_i    (req_q.op),
    .a_i     (req_q.rs_a),
    .b_i     (req_q.rs_b),
    .taken_o (cond_taken)
  );

  // Carry out of the adder is intentionally dropped: targets wrap modulo 2^32.
  assign target_d   = req_q.pc + req_q.offset;
  assign redirected = taken_q && is_aligned(target_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_EVAL;
      ST_EVAL:  state_d = (cond_taken && is_aligned(target_d)) ? ST_REDIR : ST_DONE;
      ST_REDIR: if (redirect_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == ST_IDLE);
    redirect_valid = (state_q == ST_REDIR);
    resolve_done   = (state_q == ST_DONE);
    resolve_taken  = (state_q == ST_DONE) && redirected;
    flush          = (state_q == ST_DONE) && redirected;
    resolve_err    = (state_q == ST_DONE) && taken_q && !is_aligned(target_q);
  end

  assign redirect_pc = target_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      if (state_q == ST_IDLE && req_valid) begin
        req_q <= '{op: req_op, rs_a: req_rs_a, rs_b: req_rs_b, pc: req_pc, offset: req_offset};
      end
      if (state_q == ST_EVAL) begin
        taken_q  <= cond_taken;
        target_q <= target_d;
      end
    end
  end

  // Clear wins over the increment that lands in the same DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q <= '0;
      stat_nt_q    <= '0;
    end else if (stat_clr) begin
      stat_taken_q <= '0;
      stat_nt_q    <= '0;
    end else if (state_q == ST_DONE) begin
      if (redirected) begin
        if (!(&stat_taken_q)) stat_taken_q <= stat_taken_q + STAT_ONE;
      end else begin
        if (!(&stat_nt_q)) stat_nt_q <= stat_nt_q + STAT_ONE;
      end
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_nt_q;

endmodule
